mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised N-channel memory-command arbiter, successor to the fixed two-port (instruction/data) memory interface.
- Sits between the core's request ports (fetch, load/store, DMA, etc.) and the memory map controller's start/ready/rdata_valid command bus.
- Adds selectable fixed-priority or round-robin arbitration, a command hold register that accepts requests while memory is busy, and pipelined reads with up to MAX_OUTSTANDING in-flight reads returned in order with channel routing.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUTSTANDING, 4, read-tag FIFO depth (power of two, >=1).
- RR_MODE, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- stall, in, 1, when 1 no new grants; in-flight work completes.
- req_valid, in, NUM_CH, per-channel request valid.
- req_ready, out, NUM_CH, per-channel accept; one-hot or zero.
- req_wen, in, NUM_CH, 1 = write.
- req_addr, in, NUM_CH*ADDR_W, packed, channel i at [i*ADDR_W +: ADDR_W].
- req_wdata, in, NUM_CH*DATA_W, packed write data.
- resp_valid, out, NUM_CH, read data valid for channel i.
- resp_addr, out, ADDR_W, address of the returning read.
- resp_rdata, out, DATA_W, read data, shared by all channels.
- mem_cmd_start, out, 1, command valid to the memory controller.
- mem_cmd_write, out, 1, command is a write.
- mem_cmd_ready, in, 1, memory controller accepts the command this cycle.
- mem_addr, out, ADDR_W, command address.
- mem_wdata, out, DATA_W, command write data.
- mem_rdata, in, DATA_W, read data from memory.
- mem_rdata_valid, in, 1, read data valid from memory.
- err_unexpected, out, 1, sticky: rdata_valid arrived with tag FIFO empty.

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active-low.
- Reset values:
  - state = IDLE; tag FIFO empty; round-robin pointer = 0; err_unexpected = 0.
  - While rst_n = 0: req_ready, resp_valid and mem_cmd_start are forced to 0.
- Eligibility:
  - Channel i is eligible iff req_valid[i] && (req_wen[i] || fifo_count < MAX_OUTSTANDING).
  - fifo_count is the registered count; a same-cycle pop does not free a slot.
- Grant:
  - Fixed mode: lowest-index eligible channel wins.
  - RR mode: first eligible channel searching from rr_ptr upward with wrap-around.
  - rr_ptr <= winner+1 (mod NUM_CH) on every accepted request.
- IDLE state (stall = 0, at least one channel eligible):
  - mem_cmd_* are driven combinationally from the winner; req_ready[winner] = 1 and the request is accepted this cycle.
  - If mem_cmd_ready = 1: the command is handed off in the same cycle (0-cycle latency); state stays IDLE.
  - If mem_cmd_ready = 0: {wen, addr, wdata, ch} are captured into the hold register and state goes to HOLD.
- IDLE with stall = 1 or no eligible channel: mem_cmd_start = 0 and all req_ready = 0.
- HOLD state:
  - mem_cmd_* are driven from the hold register; mem_cmd_start = 1; all req_ready = 0, regardless of stall.
  - On mem_cmd_ready: handoff and return to IDLE. No new acceptance in that cycle.
- Tag FIFO:
  - Push {ch, addr} at the handoff of a read command (IDLE-ready or HOLD-ready). Writes never push.
  - Pointers wrap mod MAX_OUTSTANDING. Push and pop in the same cycle are both performed.
- Responses:
  - When mem_rdata_valid = 1 and the FIFO is non-empty, in the same cycle: pop the head, assert resp_valid[head.ch] = 1, resp_addr = head.addr, resp_rdata = mem_rdata.
  - Responses are never back-pressured and are delivered even during stall.
- Unexpected data: mem_rdata_valid = 1 with the FIFO empty is dropped, resp_valid stays 0, and err_unexpected is set until reset.
- Reset mid-operation: the hold register contents and in-flight tags are discarded. The memory controller is reset by the same rst_n.

Decomposition:
- mem_arbiter_pkg:
  - arb_state_t enum {IDLE, HOLD}.
  - Typedef for a hold entry (wen, addr, wdata, ch) and a tag entry (ch, addr); channel index width is $clog2(NUM_CH) with a minimum of 1.
  - Localparams ARB_FIXED = 0, ARB_RR = 1.
- Sub-module mem_arb_tag_fifo: synchronous FIFO with push, pop, head, count, full and empty, parametrised by entry width and depth.

Test Plan:
- Fixed priority, NUM_CH = 3: ch0 read 0x100 and ch2 read 0x200 in the same cycle, mem_cmd_ready = 1 -> req_ready = 3'b001 and mem_addr = 0x100; next cycle ch2 is granted with mem_addr = 0x200.
- RR_MODE = 1, all 3 channels hold req_valid continuously, mem always ready -> grants cycle ch0, ch1, ch2, ch0 on consecutive cycles.
- mem_cmd_ready = 0 for 3 cycles on a ch1 write of 0xDEADBEEF to 0x40 -> req_ready[1] pulses in cycle 0; mem_cmd_start, mem_cmd_write, mem_addr = 0x40 and mem_wdata = 0xDEADBEEF are held through cycle 3; no other req_ready is asserted during HOLD.
- MAX_OUTSTANDING = 2: three back-to-back reads from ch0 with no rdata -> third read not accepted; ch1 write still granted; the first rdata_valid (0x11) gives resp_valid[0] and resp_addr = first address; the third read is accepted in the following cycle.
- Interleaved reads ch1@0x8 then ch0@0xC, rdata 0xAA then 0xBB -> resp_valid[1] with 0xAA/0x8, then resp_valid[0] with 0xBB/0xC.
- mem_rdata_valid pulse with the FIFO empty -> no resp_valid and err_unexpected = 1 until rst_n low; rst_n low while in HOLD -> next cycle state IDLE, mem_cmd_start = 0, FIFO empty.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the N-channel memory-command arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Synchronous FIFO holding read tags so responses route back in order.
module mem_arb_tag_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wr_ptr_q + 1'b1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(rd_ptr_q + 1'b1);
    count_d = CNT_W'(count_q + CNT_W'(do_push) - CNT_W'(do_pop));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-command arbiter: fixed/round-robin grant, one-deep command
// hold register and in-order routing of pipelined read responses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RR_MODE         = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_wen,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [ADDR_W-1:0]          resp_addr,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       mem_cmd_start,
  output logic                       mem_cmd_write,
  input  logic                       mem_cmd_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rdata_valid,
  output logic                       err_unexpected
);
  localparam int unsigned CH_W  = ch_idx_w(NUM_CH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [CH_W-1:0]   ch;
  } hold_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  arb_state_t      state_q, state_d;
  hold_t           hold_q, hold_d, cmd;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d, win;
  logic            err_q, err_d;

  tag_t             tag_head, tag_din;
  logic [CNT_W-1:0] tag_count;
  logic             tag_full, tag_empty, tag_push, tag_pop;
  logic             unused_full;

  logic [NUM_CH-1:0] elig;
  logic              any_elig, found, handoff;

  assign unused_full = tag_full;

  // Eligibility uses the registered count: a same-cycle pop frees nothing.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      elig[i] = req_valid[i] & (req_wen[i] | (tag_count < CNT_W'(MAX_OUTSTANDING)));
    any_elig = |elig;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = ((RR_MODE == ARB_RR) ? int'(rr_ptr_q) + k : k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    if (state_q == HOLD) begin
      cmd = hold_q;
    end else begin
      cmd.wen   = req_wen[win];
      cmd.addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
      cmd.wdata = req_wdata[int'(win)*DATA_W +: DATA_W];
      cmd.ch    = win;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    rr_ptr_d      = rr_ptr_q;
    err_d         = err_q;
    req_ready     = '0;
    mem_cmd_start = 1'b0;
    handoff       = 1'b0;
    resp_valid    = '0;
    case (state_q)
      IDLE: begin
        if (!stall && any_elig) begin
          req_ready[win] = 1'b1;
          mem_cmd_start  = 1'b1;
          handoff        = mem_cmd_ready;
          rr_ptr_d       = (win == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(win + 1'b1);
          if (!mem_cmd_ready) begin
            hold_d  = cmd;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        mem_cmd_start = 1'b1;
        handoff       = mem_cmd_ready;
        if (mem_cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tag_push = handoff & ~cmd.wen;
    tag_pop  = mem_rdata_valid & ~tag_empty;
    if (mem_rdata_valid && tag_empty) err_d = 1'b1;
    if (tag_pop) resp_valid[tag_head.ch] = 1'b1;
    if (!rst_n) begin
      req_ready     = '0;
      mem_cmd_start = 1'b0;
      resp_valid    = '0;
      tag_push      = 1'b0;
      tag_pop       = 1'b0;
    end
  end

  assign tag_din        = '{ch: cmd.ch, addr: cmd.addr};
  assign mem_cmd_write  = cmd.wen;
  assign mem_addr       = cmd.addr;
  assign mem_wdata      = cmd.wdata;
  assign resp_addr      = tag_head.addr;
  assign resp_rdata     = mem_rdata;
  assign err_unexpected = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  mem_arb_tag_fifo #(
    .W     ($bits(tag_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (tag_din),
    .head  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share stimulus.
module tb_mem_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MO  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0, stall, mem_cmd_ready, mem_rdata_valid;
  logic [NCH-1:0]    req_valid, req_wen;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [DW-1:0]     mem_rdata;

  logic [NCH-1:0] f_ready, f_resp, r_ready, r_resp;
  logic [AW-1:0]  f_raddr, r_raddr, f_addr, r_addr;
  logic [DW-1:0]  f_rdata, r_rdata, f_wdata, r_wdata;
  logic           f_start, r_start, f_write, r_write, f_err, r_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid), .req_ready(f_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(f_resp),
    .resp_addr(f_raddr), .resp_rdata(f_rdata), .mem_cmd_start(f_start), .mem_cmd_write(f_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(f_addr), .mem_wdata(f_wdata), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .err_unexpected(f_err));

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid), .req_ready(r_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r_resp),
    .resp_addr(r_raddr), .resp_rdata(r_rdata), .mem_cmd_start(r_start), .mem_cmd_write(r_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(r_addr), .mem_wdata(r_wdata), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .err_unexpected(r_err));

  // Reference model state, one slot per instance (0 = fixed, 1 = round-robin).
  int            m_hold[2], m_hch[2], m_rr[2], m_win[2], tq_n[2];
  logic          m_hwen[2], m_err[2];
  logic [AW-1:0] m_haddr[2];
  logic [DW-1:0] m_hwdata[2];
  int            tq_ch[2][8];
  logic [AW-1:0] tq_addr[2][8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    stall = 1'b0; mem_cmd_ready = 1'b1; mem_rdata_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic set_req(input int ch, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[ch] = 1'b1;
    req_wen[ch]   = wen;
    req_addr[ch*AW +: AW]  = a;
    req_wdata[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_hch[k] = 0; m_rr[k] = 0; m_win[k] = -1; tq_n[k] = 0;
      m_hwen[k] = 1'b0; m_err[k] = 1'b0; m_haddr[k] = '0; m_hwdata[k] = '0;
    end
  endtask

  task automatic model_eval(input int k, output logic [NCH-1:0] e_ready, output logic e_start,
                            output logic e_write, output logic [AW-1:0] e_addr,
                            output logic [DW-1:0] e_wdata, output logic [NCH-1:0] e_resp,
                            output logic [AW-1:0] e_raddr);
    e_ready = '0; e_start = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
    e_resp = '0; e_raddr = '0; m_win[k] = -1;
    if (rst_n) begin
      if (m_hold[k] != 0) begin
        e_start = 1'b1; e_write = m_hwen[k]; e_addr = m_haddr[k]; e_wdata = m_hwdata[k];
      end else if (!stall) begin
        for (int j = 0; j < NCH; j++) begin
          int i;
          i = ((k == 1) ? m_rr[k] + j : j) % NCH;
          if (m_win[k] < 0 && req_valid[i] && (req_wen[i] || tq_n[k] < MO)) m_win[k] = i;
        end
        if (m_win[k] >= 0) begin
          e_ready[m_win[k]] = 1'b1;
          e_start = 1'b1;
          e_write = req_wen[m_win[k]];
          e_addr  = req_addr[m_win[k]*AW +: AW];
          e_wdata = req_wdata[m_win[k]*DW +: DW];
        end
      end
      if (mem_rdata_valid && tq_n[k] > 0) begin
        e_resp[tq_ch[k][0]] = 1'b1;
        e_raddr = tq_addr[k][0];
      end
    end
  endtask

  task automatic model_push(input int k, input int ch, input logic [AW-1:0] a);
    tq_ch[k][tq_n[k]]   = ch;
    tq_addr[k][tq_n[k]] = a;
    tq_n[k]++;
  endtask

  task automatic model_update(input int k);
    int w;
    w = m_win[k];
    if (!rst_n) begin
      m_hold[k] = 0; m_rr[k] = 0; tq_n[k] = 0; m_err[k] = 1'b0;
    end else begin
      if (mem_rdata_valid) begin
        if (tq_n[k] > 0) begin
          for (int i = 0; i < 7; i++) begin
            tq_ch[k][i] = tq_ch[k][i+1];
            tq_addr[k][i] = tq_addr[k][i+1];
          end
          tq_n[k]--;
        end else begin
          m_err[k] = 1'b1;
        end
      end
      if (m_hold[k] != 0) begin
        if (mem_cmd_ready) begin
          m_hold[k] = 0;
          if (!m_hwen[k]) model_push(k, m_hch[k], m_haddr[k]);
        end
      end else if (w >= 0) begin
        m_rr[k] = (w + 1) % NCH;
        if (mem_cmd_ready) begin
          if (!req_wen[w]) model_push(k, w, req_addr[w*AW +: AW]);
        end else begin
          m_hold[k] = 1; m_hch[k] = w; m_hwen[k] = req_wen[w];
          m_haddr[k] = req_addr[w*AW +: AW]; m_hwdata[k] = req_wdata[w*DW +: DW];
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    req_valid = '1; req_wen = '1; mem_rdata_valid = 1'b1;
    #1;
    n_checks++;
    if ({f_ready, r_ready} !== '0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b expected 000/000", f_ready, r_ready);
    end
    n_checks++;
    if ({f_start, r_start, f_resp, r_resp} !== '0) begin
      n_fail++; $display("FAIL reset_start_resp: got %b%b %b %b expected all 0", f_start, r_start, f_resp, r_resp);
    end
    tick();
    n_checks++;
    if ({f_err, r_err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_err: got %b%b expected 00", f_err, r_err);
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_req(0, 1'b0, 32'h100, '0);
    set_req(2, 1'b0, 32'h200, '0);
    #1;
    n_checks++;
    if (f_ready !== 3'b001 || f_addr !== 32'h100 || f_start !== 1'b1) begin
      n_fail++; $display("FAIL fixed_first: got ready=%b addr=%h start=%b expected 001 100 1", f_ready, f_addr, f_start);
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    n_checks++;
    if (f_ready !== 3'b100 || f_addr !== 32'h200) begin
      n_fail++; $display("FAIL fixed_second: got ready=%b addr=%h expected 100 200", f_ready, f_addr);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NCH; i++) set_req(i, 1'b1, 32'(i * 16), 32'(i));
    for (int c = 0; c < 4; c++) begin
      logic [NCH-1:0] exp_r;
      exp_r = '0;
      exp_r[c % NCH] = 1'b1;
      #1;
      n_checks++;
      if (r_ready !== exp_r) begin
        n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", c, r_ready, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_req(1, 1'b1, 32'h40, 32'hDEADBEEF);
    mem_cmd_ready = 1'b0;
    #1;
    n_checks++;
    if (f_ready !== 3'b010 || {f_start, f_write} !== 2'b11 || f_addr !== 32'h40 || f_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL hold_accept: got ready=%b sw=%b%b addr=%h wdata=%h expected 010 11 40 deadbeef",
                         f_ready, f_start, f_write, f_addr, f_wdata);
    end
    tick();
    req_valid = '0;
    set_req(0, 1'b0, 32'h300, '0);
    for (int c = 1; c <= 3; c++) begin
      mem_cmd_ready = (c == 3);
      #1;
      n_checks++;
      if (f_ready !== 3'b000 || {f_start, f_write} !== 2'b11 || f_addr !== 32'h40 || f_wdata !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL hold_cycle%0d: got ready=%b sw=%b%b addr=%h wdata=%h expected 000 11 40 deadbeef",
                           c, f_ready, f_start, f_write, f_addr, f_wdata);
      end
      tick();
    end
    mem_cmd_ready = 1'b1;
    #1;
    n_checks++;
    if (f_ready !== 3'b001 || f_addr !== 32'h300) begin
      n_fail++; $display("FAIL hold_release: got ready=%b addr=%h expected 001 300", f_ready, f_addr);
    end
    tick();
  endtask

  task automatic test_outstanding();
    do_reset();
    set_req(0, 1'b0, 32'h1000, '0);
    for (int c = 0; c < 2; c++) begin
      req_addr[0 +: AW] = 32'h1000 + 32'(c * 4);
      #1;
      n_checks++;
      if (f_ready !== 3'b001) begin
        n_fail++; $display("FAIL out_read%0d: got %b expected 001", c, f_ready);
      end
      tick();
    end
    req_addr[0 +: AW] = 32'h1008;
    set_req(1, 1'b1, 32'h2000, 32'h55);
    #1;
    n_checks++;
    if (f_ready !== 3'b010) begin
      n_fail++; $display("FAIL out_full_write: got %b expected 010", f_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h11;
    #1;
    n_checks++;
    if (f_resp !== 3'b001 || f_raddr !== 32'h1000 || f_rdata !== 32'h11 || f_ready !== 3'b000) begin
      n_fail++; $display("FAIL out_first_resp: got resp=%b addr=%h data=%h ready=%b expected 001 1000 11 000",
                         f_resp, f_raddr, f_rdata, f_ready);
    end
    tick();
    mem_rdata_valid = 1'b0;
    #1;
    n_checks++;
    if (f_ready !== 3'b001 || f_addr !== 32'h1008) begin
      n_fail++; $display("FAIL out_third_read: got ready=%b addr=%h expected 001 1008", f_ready, f_addr);
    end
    tick();
  endtask

  task automatic test_interleave();
    do_reset();
    set_req(1, 1'b0, 32'h8, '0);
    tick();
    req_valid = '0;
    set_req(0, 1'b0, 32'hC, '0);
    tick();
    req_valid = '0;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hAA;
    #1;
    n_checks++;
    if (f_resp !== 3'b010 || f_raddr !== 32'h8 || f_rdata !== 32'hAA) begin
      n_fail++; $display("FAIL inter_first: got resp=%b addr=%h data=%h expected 010 8 aa", f_resp, f_raddr, f_rdata);
    end
    tick();
    mem_rdata = 32'hBB;
    #1;
    n_checks++;
    if (f_resp !== 3'b001 || f_raddr !== 32'hC || f_rdata !== 32'hBB) begin
      n_fail++; $display("FAIL inter_second: got resp=%b addr=%h data=%h expected 001 c bb", f_resp, f_raddr, f_rdata);
    end
    tick();
    mem_rdata_valid = 1'b0;
    #1;
    n_checks++;
    if (f_resp !== 3'b000 || f_err !== 1'b0) begin
      n_fail++; $display("FAIL inter_drained: got resp=%b err=%b expected 000 0", f_resp, f_err);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h77;
    #1;
    n_checks++;
    if (f_resp !== 3'b000) begin
      n_fail++; $display("FAIL unexp_resp: got %b expected 000", f_resp);
    end
    tick();
    mem_rdata_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (f_err !== 1'b1) begin
        n_fail++; $display("FAIL unexp_sticky%0d: got %b expected 1", c, f_err);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (f_err !== 1'b0) begin
      n_fail++; $display("FAIL unexp_clear: got %b expected 0", f_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    set_req(0, 1'b0, 32'h500, '0);
    tick();
    req_addr[0 +: AW] = 32'h504;
    mem_cmd_ready = 1'b0;
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (f_start !== 1'b1 || f_addr !== 32'h504) begin
      n_fail++; $display("FAIL rsthold_inhold: got start=%b addr=%h expected 1 504", f_start, f_addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (f_start !== 1'b0) begin
      n_fail++; $display("FAIL rsthold_idle: got start=%b expected 0", f_start);
    end
    mem_rdata_valid = 1'b1;
    #1;
    n_checks++;
    if (f_resp !== 3'b000) begin
      n_fail++; $display("FAIL rsthold_fifo_empty: got resp=%b expected 000", f_resp);
    end
    tick();
    mem_rdata_valid = 1'b0;
    #1;
    n_checks++;
    if (f_err !== 1'b1) begin
      n_fail++; $display("FAIL rsthold_err: got %b expected 1", f_err);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] e_ready, e_resp, a_ready, a_resp;
    logic           e_start, e_write, a_start, a_write, a_err;
    logic [AW-1:0]  e_addr, e_raddr, a_addr, a_raddr;
    logic [DW-1:0]  e_wdata, a_wdata, a_rdata;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      stall           = ($urandom_range(0, 7) == 0);
      req_valid       = NCH'($urandom);
      req_wen         = NCH'($urandom);
      req_addr        = {$urandom, $urandom, $urandom};
      req_wdata       = {$urandom, $urandom, $urandom};
      mem_cmd_ready   = ($urandom_range(0, 2) != 0);
      mem_rdata_valid = ($urandom_range(0, 2) == 0);
      mem_rdata       = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        model_eval(k, e_ready, e_start, e_write, e_addr, e_wdata, e_resp, e_raddr);
        a_ready = k ? r_ready : f_ready;   a_start = k ? r_start : f_start;
        a_write = k ? r_write : f_write;   a_addr  = k ? r_addr  : f_addr;
        a_wdata = k ? r_wdata : f_wdata;   a_resp  = k ? r_resp  : f_resp;
        a_raddr = k ? r_raddr : f_raddr;   a_rdata = k ? r_rdata : f_rdata;
        a_err   = k ? r_err   : f_err;
        n_checks++;
        if (a_ready !== e_ready || a_start !== e_start) begin
          n_fail++; $display("FAIL rnd_grant inst%0d cyc%0d: got ready=%b start=%b expected %b %b",
                             k, cyc, a_ready, a_start, e_ready, e_start);
        end
        if (e_start) begin
          n_checks++;
          if (a_write !== e_write || a_addr !== e_addr || (e_write && a_wdata !== e_wdata)) begin
            n_fail++; $display("FAIL rnd_cmd inst%0d cyc%0d: got w=%b a=%h d=%h expected %b %h %h",
                               k, cyc, a_write, a_addr, a_wdata, e_write, e_addr, e_wdata);
          end
        end
        n_checks++;
        if (a_resp !== e_resp || (e_resp != '0 && (a_raddr !== e_raddr || a_rdata !== mem_rdata))) begin
          n_fail++; $display("FAIL rnd_resp inst%0d cyc%0d: got v=%b a=%h d=%h expected %b %h %h",
                             k, cyc, a_resp, a_raddr, a_rdata, e_resp, e_raddr, mem_rdata);
        end
        n_checks++;
        if (a_err !== m_err[k]) begin
          n_fail++; $display("FAIL rnd_err inst%0d cyc%0d: got %b expected %b", k, cyc, a_err, m_err[k]);
        end
      end
      tick();
      model_update(0);
      model_update(1);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_hold();
    test_outstanding();
    test_interleave();
    test_unexpected();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
